fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - synchronous FIFO controller driving an external dual-port RAM
// Wrap-bit pointers give full/empty without a separate counter; flags derive from registered pointers.
module fifo_ctrl #(
    parameter int ADDR_WDT = 10,
    parameter int DATA_WDT = 8,
    parameter bit DOUT_REG = 1'b1,
    parameter int AF_LVL   = 2**ADDR_WDT - 2,
    parameter int AE_LVL   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [DATA_WDT-1:0] din,
    input  logic                rd_en,
    output logic [DATA_WDT-1:0] dout,
    output logic                dout_vld,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_WDT:0]   count,
    output logic                overflow,
    output logic                underflow,
    output logic [ADDR_WDT-1:0] ram_addra,
    output logic [DATA_WDT-1:0] ram_dina,
    output logic                ram_wea,
    output logic [ADDR_WDT-1:0] ram_addrb,
    output logic [DATA_WDT-1:0] ram_dinb,
    output logic                ram_web,
    input  logic [DATA_WDT-1:0] ram_doutb
);

    localparam logic [ADDR_WDT:0] PTR_ONE = (ADDR_WDT+1)'(1);
    localparam logic [ADDR_WDT:0] AF_V    = (ADDR_WDT+1)'(AF_LVL);
    localparam logic [ADDR_WDT:0] AE_V    = (ADDR_WDT+1)'(AE_LVL);

    logic [ADDR_WDT:0] wr_ptr;
    logic [ADDR_WDT:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_ptr[ADDR_WDT-1:0] == rd_ptr[ADDR_WDT-1:0]) &&
                       (wr_ptr[ADDR_WDT] != rd_ptr[ADDR_WDT]);
        count        = wr_ptr - rd_ptr;
        almost_full  = (count >= AF_V);
        almost_empty = (count <= AE_V);
        // Reset outranks both requests, so nothing reaches the RAM while rst is high.
        push_ok      = wr_en && !full && !rst;
        pop_ok       = rd_en && !empty && !rst;
    end

    assign ram_wea   = push_ok;
    assign ram_addra = wr_ptr[ADDR_WDT-1:0];
    assign ram_dina  = din;
    assign ram_addrb = rd_ptr[ADDR_WDT-1:0];
    assign ram_dinb  = '0;
    assign ram_web   = 1'b0;
    assign dout      = ram_doutb;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end

    generate
        if (DOUT_REG) begin : g_reg_out
            logic vld_q;
            always_ff @(posedge clk) begin
                if (rst) vld_q <= 1'b0;
                else     vld_q <= pop_ok;
            end
            // A pop in flight when rst arrives is discarded rather than presented.
            assign dout_vld = vld_q && !rst;
        end else begin : g_comb_out
            assign dout_vld = pop_ok;
        end
    endgenerate

endmodule
